// File: rtl/i2f_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one pipelined i2f converter among NREQ requesters.
// Optional: define I2F_SHARE_DYNRM_EN to add the frm port for dynamic rounding mode (rm == 7).
module i2f_share_ctrl #(
    parameter int unsigned FPWID = 64,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic                       rst,
    input  logic                       clk,
    input  logic                       ce,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_op,
    input  logic [3*NREQ-1:0]          req_rm,
    input  logic [FPWID*NREQ-1:0]      req_i,
`ifdef I2F_SHARE_DYNRM_EN
    input  logic [2:0]                 frm,
`endif
    output logic                       cvt_ce,
    output logic                       cvt_op,
    output logic [2:0]                 cvt_rm,
    output logic [FPWID-1:0]           cvt_i,
    input  logic [FPWID-1:0]           cvt_o,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [FPWID-1:0]           rsp_o,
    output logic                       busy
);

    localparam int unsigned RDEPTH = LAT + 1;
    localparam int unsigned IDW    = $clog2(NREQ);
    localparam int unsigned CW     = $clog2(RDEPTH + 1);
    localparam int unsigned PW     = $clog2(RDEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [IDW-1:0]       gnt_idx, sel;
    logic                 gnt_any, issue_ok;
    logic [LAT-1:0]       tag_v_q, tag_v_d;
    logic [IDW-1:0]       tag_id_q [LAT];
    logic [IDW-1:0]       tag_id_d [LAT];
    logic [CW-1:0]        inflight, inflight_d, fcnt_q, fcnt_d;
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDW+FPWID-1:0] mem_q [RDEPTH];
    logic                 push, pop;
    logic [2:0]           rm_slice;

    function automatic logic [CW-1:0] popcnt(input logic [LAT-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int s = 0; s < LAT; s++) c = c + CW'(v[s]);
        return c;
    endfunction

    // Credit: every in-flight tag owns a FIFO slot, so a push never finds the FIFO full.
    always_comb begin
        inflight   = popcnt(tag_v_q);
        inflight_d = popcnt(tag_v_d);
        issue_ok   = ce & ~rst &
                     (({1'b0, inflight} + {1'b0, fcnt_q}) < (CW + 1)'(RDEPTH));
    end

    // Reverse scan so the first valid requester in search order from rr wins.
    always_comb begin
        logic [IDW:0] idx;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_idx = rr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_q} + (IDW + 1)'(i);
            if (idx >= (IDW + 1)'(NREQ)) idx = idx - (IDW + 1)'(NREQ);
            if (req_valid[idx[IDW-1:0]]) begin
                gnt_any = issue_ok;
                gnt_idx = idx[IDW-1:0];
            end
        end
        req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
        if (gnt_any) rr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        else         rr_d = rr_q;
    end

    always_comb begin
        sel      = gnt_any ? gnt_idx : rr_q;
        cvt_ce   = ce;
        cvt_op   = req_op[sel];
        rm_slice = req_rm[3*int'(sel) +: 3];
        cvt_i    = req_i[FPWID*int'(sel) +: FPWID];
`ifdef I2F_SHARE_DYNRM_EN
        cvt_rm   = (rm_slice == 3'd7) ? frm : rm_slice;
`else
        cvt_rm   = rm_slice;
`endif
    end

    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (ce) begin
            for (int s = LAT - 1; s > 0; s--) begin
                tag_v_d[s]  = tag_v_q[s-1];
                tag_id_d[s] = tag_id_q[s-1];
            end
            tag_v_d[0]  = gnt_any;
            tag_id_d[0] = gnt_idx;
        end
    end

    always_comb begin
        push   = ce & tag_v_q[LAT-1];
        pop    = (fcnt_q != '0) & rsp_ready;
        fcnt_d = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = (wptr_q == PW'(RDEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop)  rptr_d = (rptr_q == PW'(RDEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            tag_v_q <= '0;
            fcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int s = 0; s < LAT; s++)    tag_id_q[s] <= '0;
            for (int e = 0; e < RDEPTH; e++) mem_q[e]    <= '0;
        end else begin
            rr_q     <= rr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            fcnt_q   <= fcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            if (push) mem_q[wptr_q] <= {tag_id_q[LAT-1], cvt_o};
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state, from the occupancy the registers will hold after this edge
    always_comb begin
        state_d = state_q;
        if (inflight_d != '0)  state_d = StRun;
        else if (fcnt_d != '0) state_d = StDrain;
        else                   state_d = StIdle;
    end

    // FSM and FIFO outputs
    always_comb begin
        busy              = (state_q != StIdle);
        rsp_valid         = (fcnt_q != '0);
        {rsp_id, rsp_o}   = mem_q[rptr_q];
    end

endmodule

// File: tb/tb_i2f_share_ctrl.sv
// Scoreboard bench for i2f_share_ctrl with a toy converter and a behavioural arbitration model.
module tb_i2f_share_ctrl;

    localparam int FPWID  = 64;
    localparam int NREQ   = 4;
    localparam int LAT    = 1;
    localparam int RDEPTH = LAT + 1;

    logic                  rst, clk, ce;
    logic [NREQ-1:0]       req_valid, req_ready, req_op;
    logic [3*NREQ-1:0]     req_rm;
    logic [FPWID*NREQ-1:0] req_i;
`ifdef I2F_SHARE_DYNRM_EN
    logic [2:0]            frm;
`endif
    logic                  cvt_ce, cvt_op;
    logic [2:0]            cvt_rm;
    logic [FPWID-1:0]      cvt_i, cvt_o;
    logic                  rsp_valid, rsp_ready, busy;
    logic [1:0]            rsp_id;
    logic [FPWID-1:0]      rsp_o;

    i2f_share_ctrl #(.FPWID(FPWID), .NREQ(NREQ), .LAT(LAT)) dut (
        .rst(rst), .clk(clk), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rm(req_rm), .req_i(req_i),
`ifdef I2F_SHARE_DYNRM_EN
        .frm(frm),
`endif
        .cvt_ce(cvt_ce), .cvt_op(cvt_op), .cvt_rm(cvt_rm), .cvt_i(cvt_i), .cvt_o(cvt_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o(rsp_o),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy converter: exact integer value as a double, rounding mode folded into the low bits.
    function automatic logic [63:0] conv(input logic op, input logic [2:0] rm,
                                         input logic [63:0] x);
        real mag;
        logic [63:0] a;
        logic neg;
        neg = op & x[63];
        a   = neg ? -x : x;
        mag = 0.0;
        for (int b = 63; b >= 0; b--) mag = mag * 2.0 + (a[b] ? 1.0 : 0.0);
        return $realtobits(neg ? -mag : mag) ^ {61'd0, rm};
    endfunction

    logic [FPWID-1:0] cvt_pipe [LAT];
    always @(posedge clk) begin
        if (cvt_ce) begin
            for (int s = LAT - 1; s > 0; s--) cvt_pipe[s] <= cvt_pipe[s-1];
            cvt_pipe[0] <= conv(cvt_op, cvt_rm, cvt_i);
        end
    end
    assign cvt_o = cvt_pipe[LAT-1];

    typedef struct {
        int          id;
        logic [63:0] data;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    int passed = 0;
    int total  = 0;

    int m_rr   = 0;
    int m_fcnt = 0;
    int m_tag [LAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic model_clear();
        m_rr   = 0;
        m_fcnt = 0;
        for (int s = 0; s < LAT; s++) m_tag[s] = 0;
    endtask

    // One cycle: predict grant and status at the negedge, then advance the model over the edge.
    task automatic step();
        int g, infl, push, pop;
        logic [NREQ-1:0] exp_ready;
        logic [2:0] rm;
        @(negedge clk);
        infl = 0;
        for (int s = 0; s < LAT; s++) infl += m_tag[s];
        g = -1;
        if (!rst && ce && (infl + m_fcnt < RDEPTH)) begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (m_rr + i) % NREQ;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_fcnt > 0));
        check("busy", 64'(busy), 64'((infl + m_fcnt) > 0));
        if (g >= 0) begin
            rm = req_rm[3*g +: 3];
`ifdef I2F_SHARE_DYNRM_EN
            if (rm == 3'd7) rm = frm;
            check("cvt_rm", 64'(cvt_rm), 64'(rm));
`endif
            exp_q.push_back('{g, conv(req_op[g], rm, req_i[FPWID*g +: FPWID])});
        end
        if (rst) begin
            model_clear();
        end else begin
            pop  = (m_fcnt > 0 && rsp_ready) ? 1 : 0;
            push = 0;
            if (ce) begin
                push = m_tag[LAT-1];
                for (int s = LAT - 1; s > 0; s--) m_tag[s] = m_tag[s-1];
                m_tag[0] = (g >= 0) ? 1 : 0;
            end
            m_fcnt = m_fcnt + push - pop;
            if (g >= 0) m_rr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NREQ; k++) begin
            if ($urandom_range(0, 1) == 1) req_i[FPWID*k +: FPWID] = {$urandom, $urandom};
            else req_i[FPWID*k +: FPWID] = 64'($signed($urandom_range(0, 2000)) - 1000);
        end
        req_op = NREQ'($urandom);
        req_rm = (3*NREQ)'($urandom);
`ifdef I2F_SHARE_DYNRM_EN
        frm = 3'($urandom);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_id), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_o", rsp_o, mon_e.data);
            end
        end
    end

    initial begin
        model_clear();
        rst = 1'b1; ce = 1'b0; req_valid = '0; req_op = '0; req_rm = '0; req_i = '0;
        rsp_ready = 1'b0;
`ifdef I2F_SHARE_DYNRM_EN
        frm = 3'd0;
`endif
        repeat (2) step();
        req_valid = '1; ce = 1'b1;
        step();
        rst = 1'b0; req_valid = '0;
        step();

        // Lone signed -5 from requester 2, rm 0.
        rsp_ready = 1'b1;
        req_op = 4'b0100; req_rm = '0;
        req_i[FPWID*2 +: FPWID] = -64'sd5;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        check("lat_valid", 64'(rsp_valid), 64'd1);
        check("lat_id", 64'(rsp_id), 64'd2);
        check("lat_o", rsp_o, 64'hC014_0000_0000_0000);
        repeat (3) step();

        // All requesters valid, full throughput.
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin rand_data(); step(); end

        // Back-pressure: only RDEPTH issues, then resume.
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin rand_data(); step(); end
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin rand_data(); step(); end
        req_valid = '0;
        repeat (4) step();

        // ce low for 3 cycles with one conversion in flight.
        rand_data();
        req_valid = 4'b0010;
        step();
        req_valid = '1; ce = 1'b0;
        repeat (3) step();
        req_valid = '0; ce = 1'b1;
        repeat (4) step();

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            req_valid = NREQ'($urandom);
            ce        = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Reset with two results buffered.
        ce = 1'b1; rsp_ready = 1'b0; req_valid = '1;
        repeat (5) begin rand_data(); step(); end
        check("pre_rst_full", 64'(m_fcnt), 64'(RDEPTH));
        rst = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_o", rsp_o, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        model_clear();
        repeat (2) step();
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (5) step();

        // Final drain.
        req_valid = '1;
        repeat (10) begin rand_data(); step(); end
        req_valid = '0;
        repeat (10) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
